if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//  Fetch/decode boundary register directly downstream of the program counter.
//  Captures {pc, instruction} from fetch and presents it to decode with a valid/ready handshake.
//  A 2-entry skid (main + skid slot) gives full throughput and a registered o_ready.
//  o_ready is fed back as the PC write enable. A flush injects bubbles on branch/jump redirect.
// PARAMETERS
//  ADDR_W     32             width of the PC value carried with the instruction
//  DATA_W     32             instruction width
//  NOP_INSTR  32'h0000_0000  encoding driven on o_instr while o_valid=0 (bubble)
//  CNT_W      16             width of the stall counter (optional feature only)
// PORTS
//  i_clk        in   1       clock, all state updates on rising edge
//  i_rst_n      in   1       synchronous, active-low reset
//  i_valid      in   1       fetch presents a valid {i_pc, i_instr}
//  i_pc         in   ADDR_W  PC of the fetched instruction
//  i_instr      in   DATA_W  fetched instruction word
//  o_ready      out  1       buffer can accept this cycle; drives the PC write enable
//  o_valid      out  1       decode-side entry valid
//  o_pc         out  ADDR_W  PC of the presented instruction
//  o_instr      out  DATA_W  presented instruction, or NOP_INSTR when o_valid=0
//  i_ready      in   1       decode consumes the entry this cycle; 0 = hazard stall
//  i_flush      in   1       discard all held and incoming entries
//  o_stall_cnt  out  CNT_W   present only with IF_ID_STALL_CNT_EN
// BEHAVIOUR
//  - Reset (i_rst_n=0 at an edge):
//    o_valid=0, o_pc=0, o_instr=NOP_INSTR, o_ready=1, skid slot empty, o_stall_cnt=0.
//  - Priority: reset > flush > normal operation.
//  - Handshake: accept = i_valid & o_ready; consume = o_valid & i_ready.
//  - o_ready is registered and equals ~skid_valid. It never depends combinationally on i_ready.
//  - Main slot is free when !o_valid or consume. When free, it loads:
//    - the skid slot if the skid slot is valid, else
//    - the input if accepted, else
//    - it goes invalid (o_instr=NOP_INSTR, o_pc holds its last value).
//  - The skid slot loads the input when accept occurs and the main slot is not free.
//    It empties when its contents move to the main slot.
//  - Latency: an input accepted at edge N is on o_* after edge N (1 cycle) if the buffer was empty.
//  - Throughput: one entry per cycle with i_ready held at 1. No bubbles inserted.
//  - Stall (o_valid=1, i_ready=0): o_pc and o_instr are stable. A second accept fills skid.
//    o_ready drops the next cycle, freezing the PC.
//  - Order is strictly FIFO; no entry is duplicated or dropped except by flush/reset.
//  - Flush: at the edge, both slots are invalidated and o_instr=NOP_INSTR.
//    A same-cycle input is discarded even if i_valid=1. o_ready=1 next cycle. o_pc holds.
//  - Skid full and consume in the same cycle: skid moves to main.
//    A same-cycle input cannot be accepted (o_ready=0); o_ready returns to 1 next cycle.
//  - PC values pass through unmodified; no arithmetic, wrap at 2^ADDR_W is the producer's concern.
// CONFIGURATION
//  - IF_ID_STALL_CNT_EN defined:
//    o_stall_cnt counts cycles with o_valid & ~i_ready and saturates at 2^CNT_W-1.
//    It is cleared by reset only; flush does not clear it.
//  - Not defined: the port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared include mips_defs.vh:
//    - instruction/address width constants and NOP encoding;
//    - the pipeline-slot field layout (valid, pc, instr) reused by the later stage registers.
//  - Sub-module if_id_slot: one valid+pc+instr register with load/clear/hold.
//    Instantiated twice (main, skid). Top level holds the steering logic only.
// TESTING
//  - Reset: hold i_rst_n=0 two edges with i_valid=1.
//    -> o_valid=0, o_instr=0, o_pc=0, o_ready=1; nothing captured.
//  - Streaming: pc 0..7 with i_ready=1, one per cycle.
//    -> o_pc=0..7 on consecutive cycles, 1-cycle latency, o_ready never 0.
//  - Stall:
//    - with i_ready=0 from cycle 3, offer pc 0x10, 0x11, 0x12
//      -> o_pc stuck at 0x10; 0x11 in skid; o_ready=0 and 0x12 not accepted;
//    - then raise i_ready -> 0x10, 0x11, 0x12 delivered in order, none lost.
//  - Flush: skid full (0x20 main, 0x21 skid), pulse i_flush with i_valid=1 pc 0x22.
//    -> next cycle o_valid=0, o_instr=NOP_INSTR, o_ready=1; 0x20-0x22 never appear.
//  - Flush vs reset: assert both on the same edge -> state equals reset values, o_pc=0.
//  - IF_ID_STALL_CNT_EN with CNT_W=4: hold a stall for 20 cycles -> o_stall_cnt=15 (saturated).
//    Flush -> stays 15; reset -> 0.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID boundary register: default widths, the
// bubble encoding and the command set understood by a single pipeline slot.
package if_id_buffer_pkg;

    localparam int unsigned IF_ID_ADDR_W = 32;
    localparam int unsigned IF_ID_DATA_W = 32;
    localparam logic [31:0] IF_ID_NOP    = 32'h0000_0000;

    // What a slot does at the next rising edge.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'b00,
        SLOT_LOAD  = 2'b01,
        SLOT_CLEAR = 2'b10
    } slot_cmd_e;

endpackage

// File: rtl/if_id_slot.sv
// One pipeline slot: valid bit plus {pc, instr}. Load captures new contents,
// clear drops the valid bit while leaving pc/instr untouched, hold keeps all.
module if_id_slot
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned          ADDR_W    = IF_ID_ADDR_W,
    parameter int unsigned          DATA_W    = IF_ID_DATA_W,
    parameter logic [DATA_W-1:0]    NOP_INSTR = IF_ID_NOP[DATA_W-1:0]
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  slot_cmd_e         cmd_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    // Decode the slot command into next-state values.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (cmd_i)
            SLOT_LOAD: begin
                valid_d = 1'b1;
                pc_d    = pc_i;
                instr_d = instr_i;
            end
            SLOT_CLEAR: valid_d = 1'b0;
            default:    valid_d = valid_q;
        endcase
    end

    // Slot register with synchronous active-low reset to an empty bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID boundary register with a two-entry skid (main + skid slot).
// o_ready is the registered inverse of the skid valid bit and feeds the PC
// write enable; i_flush turns both slots into bubbles on a redirect.
// Optional feature macro: IF_ID_STALL_CNT_EN adds a saturating stall counter
// on o_stall_cnt (parameter CNT_W exists only in that build).
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned       ADDR_W    = IF_ID_ADDR_W,
    parameter int unsigned       DATA_W    = IF_ID_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = IF_ID_NOP[DATA_W-1:0]
`ifdef IF_ID_STALL_CNT_EN
    ,
    parameter int unsigned       CNT_W     = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic              o_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr,
    input  logic              i_ready,
    input  logic              i_flush
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    logic              mainValid, skidValid;
    logic [ADDR_W-1:0] mainPc, skidPc, mainLoadPc;
    logic [DATA_W-1:0] mainInstr, skidInstr, mainLoadInstr;
    logic              accept, consume, mainFree;
    slot_cmd_e         mainCmd, skidCmd;

    assign accept   = i_valid & o_ready;
    assign consume  = mainValid & i_ready;
    assign mainFree = ~mainValid | consume;

    // Steer the slots: flush empties both, the main slot prefers the older skid
    // entry over fresh input, and the skid only catches input the main cannot take.
    always_comb begin
        mainCmd       = SLOT_HOLD;
        skidCmd       = SLOT_HOLD;
        mainLoadPc    = i_pc;
        mainLoadInstr = i_instr;
        if (i_flush) begin
            mainCmd = SLOT_CLEAR;
            skidCmd = SLOT_CLEAR;
        end else begin
            if (mainFree) begin
                if (skidValid) begin
                    mainCmd       = SLOT_LOAD;
                    mainLoadPc    = skidPc;
                    mainLoadInstr = skidInstr;
                    skidCmd       = SLOT_CLEAR;
                end else if (accept) begin
                    mainCmd = SLOT_LOAD;
                end else begin
                    mainCmd = SLOT_CLEAR;
                end
            end else if (accept) begin
                skidCmd = SLOT_LOAD;
            end
        end
    end

    if_id_slot #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .cmd_i   (mainCmd),
        .pc_i    (mainLoadPc),
        .instr_i (mainLoadInstr),
        .valid_o (mainValid),
        .pc_o    (mainPc),
        .instr_o (mainInstr)
    );

    if_id_slot #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .cmd_i   (skidCmd),
        .pc_i    (i_pc),
        .instr_i (i_instr),
        .valid_o (skidValid),
        .pc_o    (skidPc),
        .instr_o (skidInstr)
    );

    // Present the main slot; a bubble always shows the NOP encoding.
    always_comb begin
        o_ready = ~skidValid;
        o_valid = mainValid;
        o_pc    = mainPc;
        o_instr = mainValid ? mainInstr : NOP_INSTR;
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    // Count decode-side stall cycles, sticking at the maximum value.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !i_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed testbench for if_id_buffer: reset, streaming, stall/skid, flush,
// flush-vs-reset and (with IF_ID_STALL_CNT_EN) the saturating stall counter.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInstr;
    logic        outReady;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic        decReady;
    logic        flush;
`ifdef IF_ID_STALL_CNT_EN
    logic [3:0]  stallCnt;
`endif

    int checks = 0;
    int errors = 0;

    if_id_buffer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NOP_INSTR (NOP)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .CNT_W     (4)
`endif
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_valid     (inValid),
        .i_pc        (inPc),
        .i_instr     (inInstr),
        .o_ready     (outReady),
        .o_valid     (outValid),
        .o_pc        (outPc),
        .o_instr     (outInstr),
        .i_ready     (decReady),
        .i_flush     (flush)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .o_stall_cnt (stallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and advance past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
        rstN     = rst;
        inValid  = v;
        inPc     = pc;
        inInstr  = 32'hA000_0000 | pc;
        decReady = rdy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check the whole decode-side view at once.
    task automatic checkAll(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic rdy);
        checkOutput({tag, ".valid"}, {63'd0, outValid}, {63'd0, v});
        checkOutput({tag, ".pc"},    {32'd0, outPc},    {32'd0, pc});
        checkOutput({tag, ".instr"}, {32'd0, outInstr}, {32'd0, instr});
        checkOutput({tag, ".ready"}, {63'd0, outReady}, {63'd0, rdy});
    endtask

    initial begin
        rstN = 1'b0; inValid = 1'b0; inPc = '0; inInstr = '0; decReady = 1'b0; flush = 1'b0;

        // Reset held two edges with valid input: nothing captured.
        applyStimulus(1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h56, 1'b1, 1'b0);
        checkAll("reset", 1'b0, 32'h0, NOP, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("idle", 1'b0, 32'h0, NOP, 1'b1);

        // Streaming pc 0..7 with decode always ready, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i), 1'b1, 1'b0);
            checkAll($sformatf("stream%0d", i), 1'b1, 32'(i), 32'hA000_0000 | 32'(i), 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("drain", 1'b0, 32'h7, NOP, 1'b1);

        // Stall: 0x10 in main, 0x11 in skid, 0x12 refused.
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
        checkAll("stall10", 1'b1, 32'h10, 32'hA000_0010, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        checkAll("stall11", 1'b1, 32'h10, 32'hA000_0010, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h12, 1'b0, 1'b0);
        checkAll("stall12", 1'b1, 32'h10, 32'hA000_0010, 1'b0);
        // Release: skid moves up, 0x12 only accepted once ready returns.
        applyStimulus(1'b1, 1'b1, 32'h12, 1'b1, 1'b0);
        checkAll("rel11", 1'b1, 32'h11, 32'hA000_0011, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h12, 1'b1, 1'b0);
        checkAll("rel12", 1'b1, 32'h12, 32'hA000_0012, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("relEmpty", 1'b0, 32'h12, NOP, 1'b1);

        // Flush with both slots full and a valid same-cycle input.
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h21, 1'b0, 1'b0);
        checkAll("preFlush", 1'b1, 32'h20, 32'hA000_0020, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h22, 1'b0, 1'b1);
        checkAll("flush", 1'b0, 32'h20, NOP, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("postFlush", 1'b0, 32'h20, NOP, 1'b1);

        // Flush and reset on the same edge: reset wins, o_pc returns to 0.
        applyStimulus(1'b1, 1'b1, 32'h30, 1'b1, 1'b0);
        checkAll("load30", 1'b1, 32'h30, 32'hA000_0030, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h31, 1'b1, 1'b1);
        checkAll("flushRst", 1'b0, 32'h0, NOP, 1'b1);

`ifdef IF_ID_STALL_CNT_EN
        // Hold a 20-cycle stall: a 4-bit counter saturates at 15.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        checkOutput("cntStart", {60'd0, stallCnt}, 64'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("cntSat", {60'd0, stallCnt}, 64'd15);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("cntFlush", {60'd0, stallCnt}, 64'd15);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("cntRst", {60'd0, stallCnt}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
